query_host_bridge: RTL

QUERY_HOST_BRIDGE -- requirements
Module: query_host_bridge

---
 rtl/query_host_bridge_pkg.sv | 6 +
 rtl/query_host_bridge_result_fifo.sv | 45 ++++
 rtl/query_host_bridge.sv | 138 +++++++++++++
 3 files changed

// File: rtl/query_host_bridge_pkg.sv
// query_bridge_pkg: shared constants and FSM state encoding for the query host bridge
package query_bridge_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] SENTINEL = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, RUN} state_t;
endpackage

// File: rtl/query_host_bridge_result_fifo.sv
// result_fifo: show-ahead result FIFO; a push on a full FIFO succeeds only alongside a pop
module result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr;
  logic [AW-1:0]         r_rd;
  logic [AW:0]           r_count;
  logic                  w_push;
  logic                  w_pop;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  // Storage array; contents are don't-care until covered by the count
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/query_host_bridge.sv
// query_host_bridge: parses sentinel-framed host words into a query frame, hands it to the engine and buffers results
module query_host_bridge
  import query_bridge_pkg::*;
#(
  parameter int DIM         = 4,
  parameter int K_WIDTH     = 16,
  parameter int RES_DEPTH   = 8,
  parameter int TIMEOUT     = 1000000,
  parameter int CHANGE_MODE = 0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [WORD_W-1:0]            word_in,
  input  logic                         word_valid_in,
  output logic [DIM-1:0][WORD_W-1:0]   query_out,
  output logic [K_WIDTH-1:0]           k_out,
  output logic [WORD_W-1:0]            vertex_id_out,
  output logic                         frame_valid_out,
  input  logic                         frame_ready_in,
  input  logic [WORD_W-1:0]            result_in,
  input  logic                         result_valid_in,
  input  logic                         result_done_in,
  input  logic                         result_deq_in,
  output logic [WORD_W-1:0]            result_data_out,
  output logic                         result_empty_out,
  output logic [$clog2(RES_DEPTH):0]   result_count_out,
  output logic                         overflow_out,
  output logic [31:0]                  cycles_out,
  output logic [7:0]                   err_count_out,
  output logic                         busy_out
);
  localparam int IW = $clog2(DIM + 2);
  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  logic [WORD_W-1:0]   r_prev_word;
  logic [WORD_W-1:0]   r_buf [DIM+1];
  logic [IW-1:0]       r_idx;
  logic [31:0]         r_idle;
  logic                w_acc;
  logic                w_sent;
  logic                w_last;
  logic                w_tmo;
  logic                w_enter;
  logic                w_fire;
  logic                w_err;
  logic                w_push;
  logic                w_full;
  logic                w_drop;
  assign w_rst_n         = r_rst_sync[1];
  assign w_acc           = (CHANGE_MODE != 0) ? (word_in != r_prev_word) : word_valid_in;
  assign w_sent          = (word_in == SENTINEL);
  assign w_last          = (r_idx == IW'(DIM + 1));
  assign w_tmo           = (r_state == COLLECT) && !w_acc && (r_idle == 32'(TIMEOUT - 1));
  assign w_enter         = (r_state == IDLE) && w_acc && w_sent;
  assign w_fire          = (r_state == ISSUE) && frame_ready_in;
  assign w_err           = ((r_state == COLLECT) && w_acc && w_sent) || w_tmo;
  assign w_push          = result_valid_in && (r_state == RUN);
  assign w_drop          = w_push && w_full && !result_deq_in;
  assign frame_valid_out = (r_state == ISSUE);
  assign busy_out        = (r_state != IDLE);
  // Reset asserts immediately but releases only after two clean clock edges
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_rst_sync <= 2'b00;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  // FSM state register
  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_enter ? COLLECT : IDLE;
      COLLECT: w_next = (w_acc && !w_sent && w_last) ? ISSUE : (w_tmo ? IDLE : COLLECT);
      ISSUE:   w_next = frame_ready_in ? RUN : ISSUE;
      RUN:     w_next = result_done_in ? IDLE : RUN;
      default: w_next = IDLE;
    endcase
  end
  // Previous word tracks every cycle so change-detect mode sees each transition
  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) r_prev_word <= '0;
    else r_prev_word <= word_in;
  end
  // Frame collection; the last word goes straight to the outputs together with the buffered ones
  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_idx         <= '0;
      r_idle        <= '0;
      query_out     <= '0;
      k_out         <= '0;
      vertex_id_out <= '0;
      for (int i = 0; i <= DIM; i++) r_buf[i] <= '0;
    end else if (w_enter) begin
      r_idx  <= '0;
      r_idle <= '0;
    end else if (r_state == COLLECT) begin
      r_idle <= w_acc ? '0 : r_idle + 32'd1;
      if (w_acc && w_sent) r_idx <= '0;
      else if (w_acc) begin
        r_idx <= r_idx + IW'(1);
        if (!w_last) r_buf[r_idx] <= word_in;
        else begin
          for (int i = 0; i < DIM; i++) query_out[i] <= r_buf[i];
          k_out         <= r_buf[DIM][K_WIDTH-1:0];
          vertex_id_out <= word_in;
        end
      end
    end
  end
  // Latency, overflow and error bookkeeping
  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      cycles_out    <= '0;
      overflow_out  <= 1'b0;
      err_count_out <= '0;
    end else begin
      cycles_out    <= w_fire ? '0 : ((r_state == RUN && cycles_out != '1) ? cycles_out + 32'd1 : cycles_out);
      overflow_out  <= w_fire ? 1'b0 : (overflow_out || w_drop);
      err_count_out <= (w_err && err_count_out != 8'hFF) ? err_count_out + 8'd1 : err_count_out;
    end
  end
  result_fifo #(.DATA_WIDTH(WORD_W), .DEPTH(RES_DEPTH)) u_fifo (
    .i_clk   (clk_in),
    .i_rst_n (w_rst_n),
    .i_push  (w_push),
    .i_pop   (result_deq_in),
    .i_data  (result_in),
    .o_data  (result_data_out),
    .o_empty (result_empty_out),
    .o_full  (w_full),
    .o_count (result_count_out)
  );
endmodule
